// File: rtl/countdown_mmss_if.sv
// Control/status bundle for the MM:SS countdown timer.
// Strobes are sampled on the rising clk edge. There is no backpressure: every strobe is acted on or ignored in the cycle it is seen.
interface countdown_mmss_if;
  logic        tick;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] q;
  logic        running;
  logic        zero;
  logic        done;
  logic        load_err;
  logic [1:0]  state_dbg;

  modport master (
    output tick, load, load_val, start, pause, clear,
    input  q, running, zero, done, load_err, state_dbg
  );

  modport slave (
    input  tick, load, load_val, start, pause, clear,
    output q, running, zero, done, load_err, state_dbg
  );
endinterface

// File: rtl/countdown_mmss.sv
// BCD MM:SS countdown timer with range-checked load and a one-cycle done pulse at 00:00.
// Command priority per cycle: clear > load > start > pause > tick; only the winner is considered.
module countdown_mmss #(
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input logic               clk,
    input logic               rst,
    countdown_mmss_if.slave   bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] M10_MAX = 4'(MIN_TENS_MAX);

    state_t      state;
    logic [15:0] q;
    logic        running;
    logic        done;
    logic        load_err;
    logic        load_ok;
    logic [15:0] q_dec;

    // One-second decrement with per-digit borrow; 00:00 is never fed in.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [3:0] s1, s10, m1, m10;
        {m10, m1, s10, s1} = v;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign load_ok = (bus.load_val[3:0]   <= 4'd9) &&
                     (bus.load_val[7:4]   <= 4'd5) &&
                     (bus.load_val[11:8]  <= 4'd9) &&
                     (bus.load_val[15:12] <= M10_MAX);
    assign q_dec   = dec_bcd(q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            q        <= 16'h0000;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (bus.clear) begin
                q       <= 16'h0000;
                state   <= IDLE;
                running <= 1'b0;
            end else if (bus.load) begin
                if (state != RUN) begin
                    if (load_ok) begin
                        q       <= bus.load_val;
                        state   <= IDLE;
                        running <= 1'b0;
                    end else begin
                        load_err <= 1'b1;
                    end
                end
            end else if (bus.start) begin
                if ((state == IDLE || state == PAUSE) && q != 16'h0000) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else if (bus.pause) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (bus.tick && state == RUN) begin
                q <= q_dec;
                if (q_dec == 16'h0000) begin
                    state   <= DONE;
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign bus.q         = q;
    assign bus.running   = running;
    assign bus.zero      = (q == 16'h0000);
    assign bus.done      = done;
    assign bus.load_err  = load_err;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: directed scenarios plus random commands against a seconds-based model.
module tb_countdown_mmss;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  countdown_mmss_if ifc ();

  countdown_mmss #(.MIN_TENS_MAX(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as an integer count of seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int   m_secs = 0;
  int   m_st   = M_IDLE;
  logic m_done = 1'b0;
  logic m_err  = 1'b0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] s2bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic int bcd2s(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit legal(input logic [15:0] v);
    return v[3:0] <= 9 && v[7:4] <= 5 && v[11:8] <= 9 && v[15:12] <= 5;
  endfunction

  task automatic model_step(input logic r, c, l, input logic [15:0] lv, input logic s, p, t);
    if (r) begin
      m_secs = 0; m_st = M_IDLE; m_done = 0; m_err = 0;
    end else begin
      m_done = 0; m_err = 0;
      if (c) begin
        m_secs = 0; m_st = M_IDLE;
      end else if (l) begin
        if (m_st != M_RUN) begin
          if (legal(lv)) begin m_secs = bcd2s(lv); m_st = M_IDLE; end
          else m_err = 1;
        end
      end else if (s) begin
        if ((m_st == M_IDLE || m_st == M_PAUSE) && m_secs != 0) m_st = M_RUN;
      end else if (p) begin
        if (m_st == M_RUN) m_st = M_PAUSE;
      end else if (t && m_st == M_RUN) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin m_st = M_DONE; m_done = 1; end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, settle past the edge.
  task automatic step(input logic r, c, l, input logic [15:0] lv, input logic s, p, t);
    rst = r; ifc.clear = c; ifc.load = l; ifc.load_val = lv;
    ifc.start = s; ifc.pause = p; ifc.tick = t;
    @(posedge clk);
    model_step(r, c, l, lv, s, p, t);
    #1;
  endtask

  task automatic idle();         step(0, 0, 0, 16'h0, 0, 0, 0); endtask
  task automatic do_load(input logic [15:0] v); step(0, 0, 1, v, 0, 0, 0); endtask
  task automatic do_start();     step(0, 0, 0, 16'h0, 1, 0, 0); endtask
  task automatic do_pause();     step(0, 0, 0, 16'h0, 0, 1, 0); endtask
  task automatic do_tick();      step(0, 0, 0, 16'h0, 0, 0, 1); endtask
  task automatic do_clear();     step(0, 1, 0, 16'h0, 0, 0, 0); endtask

  task automatic test_reset();
    step(1, 0, 0, 16'h0, 0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0, 0);
    n_checks++;
    if ({ifc.q, ifc.running, ifc.done, ifc.load_err, ifc.zero} !== {16'h0000, 4'b0001})
      $display("FAIL reset: got q=%h run=%b done=%b err=%b zero=%b, want 0000/0/0/0/1",
               ifc.q, ifc.running, ifc.done, ifc.load_err, ifc.zero);
    else n_pass++;
    idle();
  endtask

  task automatic test_borrow();
    do_load(16'h0100); do_start(); do_tick();
    n_checks++;
    if ({ifc.q, ifc.running} !== {16'h0059, 1'b1})
      $display("FAIL borrow_0100: got q=%h run=%b, want 0059/1", ifc.q, ifc.running);
    else n_pass++;
    do_clear();
    do_load(16'h1000); do_start(); do_tick();
    n_checks++;
    if (ifc.q !== 16'h0959) $display("FAIL borrow_1000: got %h, want 0959", ifc.q);
    else n_pass++;
    do_clear();
  endtask

  task automatic test_done();
    do_load(16'h0002); do_start(); do_tick();
    n_checks++;
    if (ifc.q !== 16'h0001) $display("FAIL done_first_tick: got %h, want 0001", ifc.q);
    else n_pass++;
    do_tick();
    n_checks++;
    if ({ifc.q, ifc.done, ifc.running, ifc.zero, ifc.state_dbg} !== {16'h0000, 3'b101, 2'd3})
      $display("FAIL done_reach: got q=%h done=%b run=%b zero=%b st=%0d, want 0000/1/0/1/3",
               ifc.q, ifc.done, ifc.running, ifc.zero, ifc.state_dbg);
    else n_pass++;
    idle();
    n_checks++;
    if (ifc.done !== 1'b0) $display("FAIL done_width: got done=%b, want 0", ifc.done);
    else n_pass++;
    do_start(); do_tick(); do_tick();
    n_checks++;
    if ({ifc.q, ifc.running, ifc.done} !== {16'h0000, 2'b00})
      $display("FAIL done_hold: got q=%h run=%b done=%b, want 0000/0/0", ifc.q, ifc.running, ifc.done);
    else n_pass++;
  endtask

  task automatic test_load_err();
    do_load(16'h0042);
    do_load(16'h0060);
    n_checks++;
    if ({ifc.q, ifc.load_err} !== {16'h0042, 1'b1})
      $display("FAIL load_err_s10: got q=%h err=%b, want 0042/1", ifc.q, ifc.load_err);
    else n_pass++;
    idle();
    n_checks++;
    if (ifc.load_err !== 1'b0) $display("FAIL load_err_width: got %b, want 0", ifc.load_err);
    else n_pass++;
    do_load(16'h6000);
    n_checks++;
    if ({ifc.q, ifc.load_err} !== {16'h0042, 1'b1})
      $display("FAIL load_err_m10: got q=%h err=%b, want 0042/1", ifc.q, ifc.load_err);
    else n_pass++;
    do_load(16'h5959);
    n_checks++;
    if ({ifc.q, ifc.load_err} !== {16'h5959, 1'b0})
      $display("FAIL load_max: got q=%h err=%b, want 5959/0", ifc.q, ifc.load_err);
    else n_pass++;
  endtask

  task automatic test_pause_resume();
    do_load(16'h0130); do_start();
    repeat (3) do_tick();
    n_checks++;
    if (ifc.q !== 16'h0127) $display("FAIL run3: got %h, want 0127", ifc.q);
    else n_pass++;
    do_pause();
    repeat (5) do_tick();
    n_checks++;
    if ({ifc.q, ifc.running} !== {16'h0127, 1'b0})
      $display("FAIL paused: got q=%h run=%b, want 0127/0", ifc.q, ifc.running);
    else n_pass++;
    do_start(); do_tick();
    n_checks++;
    if (ifc.q !== 16'h0126) $display("FAIL resume: got %h, want 0126", ifc.q);
    else n_pass++;
    do_load(16'h0500);
    n_checks++;
    if ({ifc.q, ifc.running, ifc.load_err} !== {16'h0126, 2'b10})
      $display("FAIL load_in_run: got q=%h run=%b err=%b, want 0126/1/0", ifc.q, ifc.running, ifc.load_err);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_clear();
    do_load(16'h0010);
    step(0, 0, 0, 16'h0, 1, 0, 1);
    n_checks++;
    if ({ifc.q, ifc.running} !== {16'h0010, 1'b1})
      $display("FAIL start_tick: got q=%h run=%b, want 0010/1", ifc.q, ifc.running);
    else n_pass++;
    repeat (3) do_tick();
    n_checks++;
    if (ifc.q !== 16'h0007) $display("FAIL held_tick: got %h, want 0007", ifc.q);
    else n_pass++;
    step(0, 0, 0, 16'h0, 0, 1, 1);
    n_checks++;
    if ({ifc.q, ifc.running} !== {16'h0007, 1'b0})
      $display("FAIL pause_tick: got q=%h run=%b, want 0007/0", ifc.q, ifc.running);
    else n_pass++;
  endtask

  task automatic test_rst_clear();
    do_load(16'h0500); do_start(); do_tick();
    step(1, 0, 0, 16'h0, 0, 0, 0);
    n_checks++;
    if ({ifc.q, ifc.running, ifc.done} !== {16'h0000, 2'b00})
      $display("FAIL rst_mid_run: got q=%h run=%b done=%b, want 0000/0/0", ifc.q, ifc.running, ifc.done);
    else n_pass++;
    idle();
    do_load(16'h0300); do_start(); do_tick(); do_pause(); do_clear();
    n_checks++;
    if ({ifc.q, ifc.running, ifc.done, ifc.state_dbg} !== {16'h0000, 2'b00, 2'd0})
      $display("FAIL clear_pause: got q=%h run=%b done=%b st=%0d, want 0000/0/0/0",
               ifc.q, ifc.running, ifc.done, ifc.state_dbg);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] lv;
    logic [15:0] got_exp;
    int errs = 0;
    do_load(16'h0012);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0)
        lv = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      else if ($urandom_range(0, 3) == 0)
        lv = 16'($urandom);
      else
        lv = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0, lv,
           $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
      exp_q.push_back(s2bcd(m_secs));
      got_exp = exp_q.pop_front();
      n_checks++;
      if ({ifc.q, ifc.running, ifc.done, ifc.load_err, ifc.zero} !==
          {got_exp, m_st == M_RUN, m_done, m_err, m_secs == 0}) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got q=%h run=%b done=%b err=%b zero=%b, want %h/%b/%b/%b/%b",
                   i, ifc.q, ifc.running, ifc.done, ifc.load_err, ifc.zero,
                   got_exp, m_st == M_RUN, m_done, m_err, m_secs == 0);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    ifc.tick = 0; ifc.load = 0; ifc.load_val = 16'h0; ifc.start = 0; ifc.pause = 0; ifc.clear = 0;
    test_reset();
    test_borrow();
    test_done();
    test_load_err();
    test_pause_resume();
    test_same_cycle();
    test_rst_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
